// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data-cache controller slice.
//   - DW_DEFAULT   : default data/address width
//   - MT_*         : memory access type encoding (11 behaves as word)
//   - cacheState_e : controller state encoding
//   - byteEnable() : store byte-lane mask from access type and byte offset
package dcache_ctrl_pkg;

  localparam int DW_DEFAULT = 32;

  localparam logic [1:0] MT_BYTE = 2'b00;
  localparam logic [1:0] MT_HALF = 2'b01;
  localparam logic [1:0] MT_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } cacheState_e;

  function automatic logic [3:0] byteEnable(input logic [1:0] memType,
                                            input logic [1:0] offset);
    case (memType)
      MT_BYTE: byteEnable = 4'b0001 << offset;
      MT_HALF: byteEnable = offset[1] ? 4'b1100 : 4'b0011;
      default: byteEnable = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dcache_ctrl_load_extend.sv
// load_extend: picks the addressed byte/half out of a cached word and
// sign- or zero-extends it; words pass through unchanged.
// Ports:
//   word    in  DW  full aligned word
//   offset  in  2   byte offset within the word
//   memType in  2   MT_BYTE / MT_HALF / MT_WORD (11 = word)
//   memSign in  1   1 = sign-extend, 0 = zero-extend
//   extData out DW  extended result
module load_extend
  import dcache_ctrl_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] word,
  input  logic [1:0]    offset,
  input  logic [1:0]    memType,
  input  logic          memSign,
  output logic [DW-1:0] extData
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    case (offset)
      2'd0:    byteSel = word[7:0];
      2'd1:    byteSel = word[15:8];
      2'd2:    byteSel = word[23:16];
      default: byteSel = word[31:24];
    endcase
    // Misaligned halves fall back to the half selected by offset[1].
    halfSel = offset[1] ? word[31:16] : word[15:0];
    case (memType)
      MT_BYTE: extData = {{(DW-8){memSign & byteSel[7]}}, byteSel};
      MT_HALF: extData = {{(DW-16){memSign & halfSel[15]}}, halfSel};
      default: extData = word;
    endcase
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, one-word-per-line, write-through /
// no-write-allocate data cache sitting in the memory stage of an in-order
// pipeline. Load hits complete in the same cycle; misses and all stores
// stall the pipeline while a single main-memory transaction completes.
// Optional build macro: DCACHE_STATS_EN adds load hit/miss counters.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid_i/we_i/addr_i        memory-stage access, held while stalled
//   req_wdata_i/memtype_i/memsign_i store data, access size, load sign
//   rdata_o, stall_o, hit_o         load result, pipeline freeze, hit flag
//   mem_req_o/we_o/addr_o/wdata_o/be_o  main-memory request
//   mem_rdata_i, mem_ack_i          main-memory read data, completion pulse
//   hit_count_o, miss_count_o       (DCACHE_STATS_EN only) load statistics
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int SETS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  input  logic          req_we_i,
  input  logic [DW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  input  logic [1:0]    req_memtype_i,
  input  logic          req_memsign_i,
  output logic [DW-1:0] rdata_o,
  output logic          stall_o,
  output logic          hit_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [3:0]    mem_be_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]   hit_count_o,
  output logic [31:0]   miss_count_o
`endif
);

  localparam int IW = $clog2(SETS);
  localparam int TW = DW - IW - 2;

  cacheState_e state, stateNext;

  logic [SETS-1:0] validArr;
  logic [TW-1:0]   tagArr  [SETS];
  logic [DW-1:0]   dataArr [SETS];

  // One-cycle marker after a memory transaction completes: the frozen
  // pipeline still presents the finished access, which must not restart.
  logic doneQ;

  logic [DW-1:0] pendAddr;
  logic [DW-1:0] pendWdata;
  logic [1:0]    pendType;

  logic [IW-1:0] reqIdx, pendIdx;
  logic [TW-1:0] reqTag, pendTag;
  logic          lookupHit, pendHit;
  logic          loadHit, loadMiss, storeNew;
  logic [3:0]    pendBe;
  logic [DW-1:0] pendRep;
  logic [DW-1:0] loadExt;

  assign reqIdx  = req_addr_i[IW+1:2];
  assign reqTag  = req_addr_i[DW-1:IW+2];
  assign pendIdx = pendAddr[IW+1:2];
  assign pendTag = pendAddr[DW-1:IW+2];

  assign lookupHit = validArr[reqIdx] && (tagArr[reqIdx] == reqTag);
  assign pendHit   = validArr[pendIdx] && (tagArr[pendIdx] == pendTag);

  assign loadHit  = (state == IDLE) && req_valid_i && !req_we_i && lookupHit;
  assign loadMiss = (state == IDLE) && req_valid_i && !req_we_i && !lookupHit;
  assign storeNew = (state == IDLE) && req_valid_i && req_we_i && !doneQ;

  assign pendBe = byteEnable(pendType, pendAddr[1:0]);

  // Store data replicated into every lane so memory can pick by byte enable.
  always_comb begin
    case (pendType)
      MT_BYTE: pendRep = {(DW/8){pendWdata[7:0]}};
      MT_HALF: pendRep = {(DW/16){pendWdata[15:0]}};
      default: pendRep = pendWdata;
    endcase
  end

  load_extend #(.DW(DW)) uLoadExtend (
    .word    (dataArr[reqIdx]),
    .offset  (req_addr_i[1:0]),
    .memType (req_memtype_i),
    .memSign (req_memsign_i),
    .extData (loadExt)
  );

  assign rdata_o     = loadHit ? loadExt : '0;
  assign hit_o       = (state == IDLE) && req_valid_i && lookupHit;
  assign mem_addr_o  = {pendAddr[DW-1:2], 2'b00};
  assign mem_wdata_o = pendRep;

  always_comb begin
    stateNext = state;
    stall_o   = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_be_o  = 4'b0000;
    case (state)
      IDLE: begin
        if (storeNew) begin
          stall_o   = 1'b1;
          stateNext = WRITE;
        end else if (loadMiss) begin
          stall_o   = 1'b1;
          stateNext = REFILL;
        end
      end
      REFILL: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        if (mem_ack_i) stateNext = IDLE;
      end
      WRITE: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        mem_be_o  = pendBe;
        if (mem_ack_i) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Control state: FSM, valid bits, completion marker
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      validArr <= '0;
      doneQ    <= 1'b0;
    end else begin
      state <= stateNext;
      doneQ <= (state != IDLE) && mem_ack_i;
      if (state == REFILL && mem_ack_i) validArr[pendIdx] <= 1'b1;
    end
  end

  // Request capture and line storage; blocked while reset is asserted so an
  // abandoned transaction never touches the array
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && req_valid_i) begin
        pendAddr  <= req_addr_i;
        pendWdata <= req_wdata_i;
        pendType  <= req_memtype_i;
      end
      if (state == REFILL && mem_ack_i) begin
        dataArr[pendIdx] <= mem_rdata_i;
        tagArr[pendIdx]  <= pendTag;
      end
      if (state == WRITE && mem_ack_i && pendHit) begin
        for (int b = 0; b < 4; b++) begin
          if (pendBe[b]) dataArr[pendIdx][8*b +: 8] <= pendRep[8*b +: 8];
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hitCnt, missCnt;

  // Replayed load after a refill belongs to the miss, not a new hit
  always_ff @(posedge clk) begin
    if (rst) begin
      hitCnt  <= 32'd0;
      missCnt <= 32'd0;
    end else begin
      if (loadHit && !doneQ) hitCnt <= hitCnt + 32'd1;
      if (state == REFILL && mem_ack_i) missCnt <= missCnt + 32'd1;
    end
  end

  assign hit_count_o  = hitCnt;
  assign miss_count_o = missCnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl (DW=32, SETS=16). Main memory is
// modelled in the bench; expected load results are queued when a load is
// issued and compared when the cache delivers it.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_we_i, req_memsign_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [1:0]  req_memtype_i;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        stall_o, hit_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [3:0]  mem_be_o;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_o, miss_count_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] mainMem [0:1023];
  logic [31:0] expQ [$];

  dcache_ctrl #(.DW(32), .SETS(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_memtype_i(req_memtype_i),
    .req_memsign_i(req_memsign_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .hit_o(hit_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
    , .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`endif
  );

  always #5 clk = ~clk;

  // Presents one access and plays main memory until the cache releases the
  // stall. Returns what was seen on the memory bus and the final load data.
  task automatic doAccess(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] mt,
                          input logic sg, input int ackDelay,
                          output logic [31:0] rd, output logic hitSeen,
                          output int stallCyc, output logic firstStall,
                          output logic [31:0] busAddr, output logic [3:0] busBe,
                          output logic busWe, output logic [31:0] busWdata,
                          output logic timedOut);
    int waitCnt;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
    req_wdata_i = wdata; req_memtype_i = mt; req_memsign_i = sg;
    stallCyc = 0; waitCnt = 0; timedOut = 1'b0;
    busAddr = 32'h0; busBe = 4'h0; busWe = 1'b0; busWdata = 32'h0;
    #1;
    firstStall = stall_o;
    while (stall_o === 1'b1) begin
      if (stallCyc >= 40) begin
        timedOut = 1'b1;
        break;
      end
      if (mem_req_o === 1'b1) begin
        busAddr = mem_addr_o; busBe = mem_be_o; busWe = mem_we_o; busWdata = mem_wdata_o;
        if (waitCnt >= ackDelay) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
              if (mem_be_o[b]) mainMem[mem_addr_o[11:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
          end else begin
            mem_rdata_i = mainMem[mem_addr_o[11:2]];
          end
        end
        waitCnt++;
      end
      @(negedge clk);
      mem_ack_i = 1'b0;
      stallCyc++;
      #1;
    end
    rd = rdata_o;
    hitSeen = hit_o;
    @(negedge clk);
    req_valid_i = 1'b0; req_we_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (stall_o !== 1'b0 || hit_o !== 1'b0 || mem_req_o !== 1'b0 ||
        mem_we_o !== 1'b0 || mem_be_o !== 4'h0 || rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs stall=%b hit=%b req=%b we=%b be=%b rdata=%h want all zero",
               stall_o, hit_o, mem_req_o, mem_we_o, mem_be_o, rdata_o);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack_ignored req=%b stall=%b want 0 0", mem_req_o, stall_o);
    end
  endtask

  task automatic test_refill();
    logic [31:0] rd, ba, bw, expv; logic [3:0] be; logic hs, fs, bwe, to; int sc;
    mainMem[10'h040] = 32'hDEADBEEF;
    expQ.push_back(32'hDEADBEEF);
    doAccess(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 1, rd, hs, sc, fs, ba, be, bwe, bw, to);
    expv = expQ.pop_front();
    checks++;
    if (to || rd !== expv) begin errors++; $display("FAIL refill_data got %h want %h to=%b", rd, expv, to); end
    checks++;
    if (fs !== 1'b1 || sc != 3) begin errors++; $display("FAIL refill_stall first=%b cycles=%0d want 1 3", fs, sc); end
    checks++;
    if (ba !== 32'h100 || bwe !== 1'b0) begin errors++; $display("FAIL refill_bus addr=%h we=%b want 00000100 0", ba, bwe); end
    checks++;
    if (hs !== 1'b1) begin errors++; $display("FAIL refill_replay_hit got %b want 1", hs); end
  endtask

  task automatic test_extend();
    logic [31:0] addrs [5] = '{32'h101, 32'h102, 32'h100, 32'h102, 32'h103};
    logic [1:0]  types [5] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b11};
    logic        signs [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exps  [5] = '{32'hFFFFFFBE, 32'h0000DEAD, 32'h000000EF, 32'hFFFFDEAD, 32'hDEADBEEF};
    logic [31:0] rd, ba, bw, expv; logic [3:0] be; logic hs, fs, bwe, to; int sc;
    for (int i = 0; i < 5; i++) begin
      expQ.push_back(exps[i]);
      doAccess(1'b0, addrs[i], 32'h0, types[i], signs[i], 0, rd, hs, sc, fs, ba, be, bwe, bw, to);
      expv = expQ.pop_front();
      checks++;
      if (rd !== expv || sc != 0 || hs !== 1'b1) begin
        errors++;
        $display("FAIL extend_%0d got %h stall=%0d hit=%b want %h 0 1", i, rd, sc, hs, expv);
      end
    end
  endtask

  task automatic test_store();
    logic [31:0] rd, ba, bw, expv; logic [3:0] be; logic hs, fs, bwe, to; int sc;
    doAccess(1'b1, 32'h103, 32'h000000AA, 2'b00, 1'b0, 2, rd, hs, sc, fs, ba, be, bwe, bw, to);
    checks++;
    if (to || be !== 4'b1000 || bwe !== 1'b1 || bw !== 32'hAAAAAAAA || ba !== 32'h100) begin
      errors++; $display("FAIL store_byte_bus be=%b we=%b wdata=%h addr=%h want 1000 1 aaaaaaaa 00000100", be, bwe, bw, ba);
    end
    checks++;
    if (fs !== 1'b1 || sc != 4) begin errors++; $display("FAIL store_byte_stall first=%b cycles=%0d want 1 4", fs, sc); end
    expQ.push_back(32'hAAADBEEF);
    doAccess(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, rd, hs, sc, fs, ba, be, bwe, bw, to);
    expv = expQ.pop_front();
    checks++;
    if (rd !== expv || sc != 0) begin errors++; $display("FAIL store_merge got %h stall=%0d want %h 0", rd, sc, expv); end
    mainMem[10'h042] = 32'h0;
    doAccess(1'b1, 32'h10A, 32'h1234C0DE, 2'b01, 1'b0, 0, rd, hs, sc, fs, ba, be, bwe, bw, to);
    checks++;
    if (be !== 4'b1100 || bw !== 32'hC0DEC0DE || ba !== 32'h108 || sc != 2) begin
      errors++; $display("FAIL store_half_bus be=%b wdata=%h addr=%h stall=%0d want 1100 c0dec0de 00000108 2", be, bw, ba, sc);
    end
    mainMem[10'h090] = 32'h0;
    doAccess(1'b1, 32'h240, 32'h11223344, 2'b10, 1'b0, 1, rd, hs, sc, fs, ba, be, bwe, bw, to);
    checks++;
    if (be !== 4'b1111 || bw !== 32'h11223344 || ba !== 32'h240) begin
      errors++; $display("FAIL store_word_bus be=%b wdata=%h addr=%h want 1111 11223344 00000240", be, bw, ba);
    end
    expQ.push_back(32'hAAADBEEF);
    doAccess(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, rd, hs, sc, fs, ba, be, bwe, bw, to);
    expv = expQ.pop_front();
    checks++;
    if (rd !== expv || sc != 0) begin errors++; $display("FAIL store_no_allocate got %h stall=%0d want %h 0", rd, sc, expv); end
    expQ.push_back(32'h0000C0DE);
    doAccess(1'b0, 32'h10A, 32'h0, 2'b01, 1'b0, 0, rd, hs, sc, fs, ba, be, bwe, bw, to);
    expv = expQ.pop_front();
    checks++;
    if (rd !== expv || sc != 2) begin errors++; $display("FAIL store_half_mem got %h stall=%0d want %h 2", rd, sc, expv); end
  endtask

  task automatic test_conflict();
    logic [31:0] rd, ba, bw, expv; logic [3:0] be; logic hs, fs, bwe, to; int sc;
    mainMem[10'h050] = 32'h0BADF00D;
    doAccess(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, rd, hs, sc, fs, ba, be, bwe, bw, to);
    expQ.push_back(32'h0BADF00D);
    doAccess(1'b0, 32'h140, 32'h0, 2'b10, 1'b0, 0, rd, hs, sc, fs, ba, be, bwe, bw, to);
    expv = expQ.pop_front();
    checks++;
    if (rd !== expv || sc != 2) begin errors++; $display("FAIL conflict_evict got %h stall=%0d want %h 2", rd, sc, expv); end
    expQ.push_back(32'hAAADBEEF);
    doAccess(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, rd, hs, sc, fs, ba, be, bwe, bw, to);
    expv = expQ.pop_front();
    checks++;
    if (rd !== expv || sc != 2) begin errors++; $display("FAIL conflict_remiss got %h stall=%0d want %h 2", rd, sc, expv); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, ba, bw, expv; logic [3:0] be; logic hs, fs, bwe, to; int sc;
    for (int i = 0; i < 6; i++) begin
      mainMem[10'h0C0 + i] = $urandom;
      for (int pass = 0; pass < 2; pass++) begin
        expQ.push_back(mainMem[10'h0C0 + i]);
        doAccess(1'b0, 32'h300 + 32'(4*i), 32'h0, 2'b10, 1'b0, i % 3, rd, hs, sc, fs, ba, be, bwe, bw, to);
        expv = expQ.pop_front();
        checks++;
        if (rd !== expv || sc != ((pass == 0) ? 2 + (i % 3) : 0)) begin
          errors++;
          $display("FAIL seq_%0d_%0d got %h stall=%0d want %h %0d", i, pass, rd, sc, expv,
                   (pass == 0) ? 2 + (i % 3) : 0);
        end
      end
    end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] rd, ba, bw, expv; logic [3:0] be; logic hs, fs, bwe, to; int sc;
    mainMem[10'h041] = 32'h12345678;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h104;
    req_memtype_i = 2'b10; req_memsign_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h104) begin
      errors++; $display("FAIL midrefill_req req=%b addr=%h want 1 00000104", mem_req_o, mem_addr_o);
    end
    rst = 1'b1; req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++; $display("FAIL midrefill_abandon req=%b stall=%b want 0 0", mem_req_o, stall_o);
    end
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++; $display("FAIL midrefill_late_ack req=%b stall=%b want 0 0", mem_req_o, stall_o);
    end
    expQ.push_back(32'hAAADBEEF);
    doAccess(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, rd, hs, sc, fs, ba, be, bwe, bw, to);
    expv = expQ.pop_front();
    checks++;
    if (rd !== expv || sc != 2) begin errors++; $display("FAIL midrefill_invalidated got %h stall=%0d want %h 2", rd, sc, expv); end
    expQ.push_back(32'h12345678);
    doAccess(1'b0, 32'h104, 32'h0, 2'b10, 1'b0, 0, rd, hs, sc, fs, ba, be, bwe, bw, to);
    expv = expQ.pop_front();
    checks++;
    if (rd !== expv || sc != 2) begin errors++; $display("FAIL midrefill_no_fill got %h stall=%0d want %h 2", rd, sc, expv); end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    logic [31:0] rd, ba, bw; logic [3:0] be; logic hs, fs, bwe, to; int sc;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if (hit_count_o !== 32'd0 || miss_count_o !== 32'd0) begin
      errors++; $display("FAIL stats_reset hits=%0d misses=%0d want 0 0", hit_count_o, miss_count_o);
    end
    doAccess(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, rd, hs, sc, fs, ba, be, bwe, bw, to);
    doAccess(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, rd, hs, sc, fs, ba, be, bwe, bw, to);
    doAccess(1'b0, 32'h101, 32'h0, 2'b00, 1'b1, 0, rd, hs, sc, fs, ba, be, bwe, bw, to);
    doAccess(1'b1, 32'h103, 32'hAA, 2'b00, 1'b0, 0, rd, hs, sc, fs, ba, be, bwe, bw, to);
    #1;
    checks++;
    if (hit_count_o !== 32'd2 || miss_count_o !== 32'd1) begin
      errors++; $display("FAIL stats_counts hits=%0d misses=%0d want 2 1", hit_count_o, miss_count_o);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mainMem[i] = 32'h0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
    req_memtype_i = 2'b10; req_memsign_i = 1'b0;
    mem_rdata_i = 32'h0; mem_ack_i = 1'b0;
    test_reset();
    test_refill();
    test_extend();
    test_store();
    test_conflict();
    test_back_to_back();
    test_reset_mid_refill();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter DW, default 32, data/address width.
REQ-002 Parameter SETS, default 16, number of direct-mapped one-word lines; power of two, >=2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid_i  input  1  memory-stage access present this cycle.
REQ-006 req_we_i  input  1  1=store, 0=load.
REQ-007 req_addr_i  input  DW  byte address (memory-stage ALU result).
REQ-008 req_wdata_i  input  DW  store data, sub-word in low bits.
REQ-009 req_memtype_i  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-010 req_memsign_i  input  1  1=sign-extend loads, 0=zero-extend.
REQ-011 rdata_o  output  DW  extended load data to memory/writeback pipeline register.
REQ-012 stall_o  output  1  freeze PC and all pipeline registers while high.
REQ-013 hit_o  output  1  lookup hit this cycle.
REQ-014 mem_req_o / mem_we_o  output  1 / 1  main-memory request and write strobe.
REQ-015 mem_addr_o / mem_wdata_o  output  DW / DW  word-aligned address, full-word write data.
REQ-016 mem_be_o  output  4  byte enables for stores.
REQ-017 mem_rdata_i / mem_ack_i  input  DW / 1  read word; single-cycle completion pulse.

Function
REQ-018 Address split: offset [1:0], index [log2(SETS)+1:2], tag remaining upper bits; misaligned accesses use the aligned word, no trap.
REQ-019 States IDLE, REFILL, WRITE; IDLE is the only state accepting requests.
REQ-020 IDLE load hit (valid && tag match): rdata_o valid combinationally same cycle, stall_o=0, hit_o=1.
REQ-021 IDLE load miss: stall_o=1 same cycle, next state REFILL.
REQ-022 REFILL: mem_req_o=1, mem_we_o=0, mem_addr_o=aligned request address held constant until mem_ack_i.
REQ-023 On mem_ack_i in REFILL: write line data/tag, set valid, go IDLE; replayed request hits next cycle; stall_o low in that hit cycle.
REQ-024 IDLE store: stall_o=1, next state WRITE (write-through, no-allocate).
REQ-025 WRITE: mem_req_o=1, mem_we_o=1, mem_be_o per type/offset (byte 0001<<off, half 0011<<{off[1],0}, word 1111), data lane-replicated.
REQ-026 Store hit: cached word byte-merged on the mem_ack_i cycle; store miss leaves array unchanged.
REQ-027 On mem_ack_i in WRITE: go IDLE; stall_o low the following cycle.
REQ-028 Load extension: byte/half selected by offset, extended per req_memsign_i; word passed unchanged.
REQ-029 stall_o = (state!=IDLE) || (IDLE && req_valid_i && (req_we_i || !hit)).
REQ-030 mem_ack_i in IDLE ignored; req_valid_i low in IDLE: no state change, stall_o=0.

Reset
REQ-031 rst clears all valid bits, state=IDLE; stall_o, hit_o, mem_req_o, mem_we_o=0, mem_be_o=0, rdata_o=0 when idle.
REQ-032 rst mid-REFILL/WRITE abandons transaction: mem_req_o low the next cycle, no array update, late ack ignored.

Configuration
REQ-033 With DCACHE_STATS_EN defined: outputs hit_count_o and miss_count_o (32-bit each) count completed load hits and load misses, wrapping at 2^32, cleared by rst.
REQ-034 Without DCACHE_STATS_EN: those ports and counters absent; all other behaviour identical.

Structure
REQ-035 Shared package holds memtype encoding constants, state enum, and DW default.
REQ-036 One sub-module, load_extend: combinational offset select and sign/zero extension; reused by any later load path.

Verification
REQ-037 After reset, load word 0x100: miss, stall 1 cycle then REFILL; ack with 0xDEADBEEF -> next cycle hit_o=1, rdata_o=0xDEADBEEF, stall_o=0.
REQ-038 Line 0x100 cached 0xDEADBEEF; signed byte load 0x101 -> 0xFFFFFFBE; unsigned half 0x102 -> 0x0000DEAD.
REQ-039 Store byte 0xAA to 0x103 (hit) -> mem_be_o=1000, stall until ack; subsequent load word 0x100 hits returning 0xAAADBEEF.
REQ-040 Conflict: load 0x100 then 0x100+4*SETS -> second misses and evicts; reload 0x100 misses again.
REQ-041 Assert rst during REFILL before ack; ack next cycle -> state IDLE, no line valid, load 0x100 misses.
REQ-042 With DCACHE_STATS_EN: sequence miss, hit, hit, store -> hit_count_o=2, miss_count_o=1.
